cache_assoc_fifo: RTL and testbench
===================================

Name: cache_assoc_fifo

Overview:
- Parametrised N-way set-associative, write-through, no-write-allocate data cache between the pipelined MIPS core's memory stage and the word-addressed dram.
- Replaces the fully-associative, zero-latency cache with:
  - real stall generation;
  - a req/ack memory handshake tolerant of any DRAM latency;
  - per-set FIFO replacement;
  - hit/miss statistics counters.
- One cache line = one DATA_W word.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, word address width.
- SETS, 16, number of sets; power of 2, >= 2.
- WAYS, 4, ways per set; power of 2, >= 1.
- CNT_W, 16, width of the hit/miss statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_re  in  1  read request; level, held by core while stall=1.
- cpu_we  in  1  write request; level, held by core while stall=1.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid when cpu_re=1 and stall=0.
- stall  out  1  core must freeze and hold its request.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req=1.
- mem_addr  out  ADDR_W  memory word address; stable while mem_req=1.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse.
- hit_cnt  out  CNT_W  read hits, saturating.
- miss_cnt  out  CNT_W  read misses, saturating.

Behaviour:
- Address split: idx = cpu_addr[log2(SETS)-1:0]; tag = remaining upper bits.
- Reset (rst_n=0, asynchronous):
  - all valid bits 0; FIFO pointers 0; state IDLE;
  - stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0;
  - hit_cnt=0, miss_cnt=0.
  - Reset mid-transaction abandons the transaction; a later mem_ack is ignored in IDLE.
- Lookup is combinational on cpu_addr across all ways of set idx. Hit = valid & tag match; at most one way can match.
- States: IDLE, RD_MISS, WR_THRU, FILL.
- IDLE:
  - cpu_we=1 (priority over cpu_re):
    - stall=1 combinationally;
    - on the hit way, data updated at the same edge;
    - FIFO pointer unchanged;
    - go WR_THRU with mem_req=1, mem_we=1, mem_addr/mem_wdata latched.
  - cpu_re=1 and hit:
    - cpu_rdata = way data in the same cycle, stall=0;
    - hit_cnt+1 at the edge;
    - 0-cycle latency.
  - cpu_re=1 and miss:
    - stall=1 combinationally;
    - miss_cnt+1; latch idx/tag;
    - go RD_MISS with mem_req=1, mem_we=0.
  - Neither request: stall=0, idle.
- RD_MISS:
  - stall=1, mem_req=1;
  - on mem_ack: write mem_rdata into way fifo_ptr[idx], set valid, store tag, fifo_ptr[idx]+1 (wraps WAYS-1 -> 0), capture cpu_rdata; go FILL.
- FILL (1 cycle):
  - stall=0, cpu_rdata = filled word;
  - back to IDLE.
  - Total read-miss stall = DRAM latency + 1 cycles.
- WR_THRU:
  - stall=1;
  - on mem_ack: mem_req=0; go IDLE with stall=0 in the next cycle.
  - A write miss does not allocate.
- Replacement: an invalid way in the set is chosen first, lowest index; otherwise the fifo_ptr[idx] victim. The pointer advances only when the FIFO victim is used.
- mem_ack outside RD_MISS/WR_THRU is ignored.
- Counters saturate at all-ones. Hit count is taken in IDLE only; the FILL cycle is not counted as a hit.
- cpu_re and cpu_we both 1: treated as a write only.

Decomposition:
- Shared package cache_pkg:
  - state encoding constants (IDLE=2'd0, RD_MISS=2'd1, WR_THRU=2'd2, FILL=2'd3);
  - functions clog2 and tag-width computation.
- One natural sub-module: cache_set_array, holding the tag/valid/data storage per set × way.
  - Combinational read of all ways of one set.
  - Synchronous write of one way.
  - FSM, FIFO pointers and counters stay in the top.

Test Plan:
- Cold read, addr 0x10 (idx 0, SETS=16), DRAM acks after 3 cycles with 0xDEADBEEF:
  - stall high 4 cycles; cpu_rdata=0xDEADBEEF in FILL;
  - miss_cnt=1.
  - Repeat read of 0x10: stall=0 same cycle, rdata=0xDEADBEEF, hit_cnt=1.
- Write 0x12345678 to cached 0x10:
  - mem_req/mem_we high with mem_addr=0x10 until ack; stall high meanwhile.
  - Subsequent read of 0x10 hits with 0x12345678.
- Write to uncached 0x20:
  - memory write issued; no allocation.
  - Read 0x20 then misses (miss_cnt+1).
- WAYS=4: read addrs 0x00, 0x10, 0x20, 0x30, 0x40 (all set 0):
  - fifth read evicts 0x00 (way 0);
  - reread 0x10 hits; reread 0x00 misses and evicts 0x10.
- rst_n pulsed low during RD_MISS before ack:
  - outputs return to reset values immediately;
  - the late mem_ack is ignored;
  - read of the same addr misses, miss_cnt=1.
- Counter saturation with CNT_W=2: 5 hits → hit_cnt=3.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative data cache.
//   cache_state_e : controller state encoding
//   clog2         : ceiling log2 of a positive integer (0 for 0 or 1)
//   tag_width     : tag bits left after removing the set index from a word address
package cache_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdMiss = 2'd1,
    StWrThru = 2'd2,
    StFill   = 2'd3
  } cache_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned sets);
    return addr_w - clog2(sets);
  endfunction

endpackage

// File: rtl/cache_set_array.sv
// Tag/valid/data storage for SETS x WAYS one-word lines.
//   clk, rst_n           : clock, async active-low reset (clears valid bits only)
//   rd_idx               : set whose ways are presented combinationally
//   rd_valid/tag/data    : per-way contents of set rd_idx
//   wr_en/idx/way/tag/data : synchronous write of one way; always marks it valid
module cache_set_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned TAG_W  = 28,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned WAY_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [WAYS-1:0]               rd_valid,
  output logic [WAYS-1:0][TAG_W-1:0]    rd_tag,
  output logic [WAYS-1:0][DATA_W-1:0]   rd_data,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [WAY_W-1:0]              wr_way,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic [DATA_W-1:0]             wr_data
);

  logic [WAYS-1:0]   valid_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) valid_q[s] <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx][wr_way] <= 1'b1;
    end
  end

  // Tags and data need no reset: they are never used while their valid bit is 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx][wr_way]  <= wr_tag;
      data_q[wr_idx][wr_way] <= wr_data;
    end
  end

  always_comb begin
    for (int w = 0; w < int'(WAYS); w++) begin
      rd_valid[w] = valid_q[rd_idx][w];
      rd_tag[w]   = tag_q[rd_idx][w];
      rd_data[w]  = data_q[rd_idx][w];
    end
  end

endmodule

// File: rtl/cache_assoc_fifo.sv
// N-way set-associative, write-through, no-write-allocate data cache with FIFO replacement.
//   clk, rst_n                    : clock, async active-low reset
//   cpu_re/we/addr/wdata          : core request, held while stall=1
//   cpu_rdata, stall              : read data (valid when cpu_re & ~stall), core freeze
//   mem_req/we/addr/wdata         : DRAM request, held until mem_ack
//   mem_rdata, mem_ack            : DRAM response, one-cycle ack pulse
//   hit_cnt, miss_cnt             : saturating read hit/miss statistics
module cache_assoc_fifo
  import cache_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned IDX_W = clog2(SETS);
  localparam int unsigned TAG_W = tag_width(ADDR_W, SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? clog2(WAYS) : 1;

  cache_state_e state_q, state_d;

  logic [IDX_W-1:0]            cpu_idx, rd_idx, wr_idx, miss_idx_q;
  logic [TAG_W-1:0]            cpu_tag, wr_tag, miss_tag_q;
  logic [WAYS-1:0]             rd_valid;
  logic [WAYS-1:0][TAG_W-1:0]  rd_tag;
  logic [WAYS-1:0][DATA_W-1:0] rd_data;
  logic                        hit, use_fifo;
  logic [WAY_W-1:0]            hit_way, victim_way, wr_way;
  logic [DATA_W-1:0]           hit_data, wr_data;
  logic                        wr_en, start_rd, start_wr, fill, hit_inc, miss_inc;
  logic [WAY_W-1:0]            fifo_ptr_q [SETS];

  logic [DATA_W-1:0] rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_req_q, mem_we_q, wr_done_q;
  logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;

  assign cpu_idx = cpu_addr[IDX_W-1:0];
  assign cpu_tag = cpu_addr[ADDR_W-1:IDX_W];
  // While a miss is outstanding, look at the latched set for victim selection.
  assign rd_idx  = (state_q == StIdle) ? cpu_idx : miss_idx_q;

  cache_set_array #(
    .DATA_W (DATA_W),
    .SETS   (SETS),
    .WAYS   (WAYS),
    .TAG_W  (TAG_W),
    .IDX_W  (IDX_W),
    .WAY_W  (WAY_W)
  ) u_set_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_way   (wr_way),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_data = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (rd_valid[w] && (rd_tag[w] == cpu_tag)) begin
        hit      = 1'b1;
        hit_way  = WAY_W'(w);
        hit_data = rd_data[w];
      end
    end
  end

  // Lowest invalid way wins; the FIFO pointer is only the victim when the set is full.
  always_comb begin
    victim_way = fifo_ptr_q[miss_idx_q];
    use_fifo   = &rd_valid;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!rd_valid[w]) victim_way = WAY_W'(w);
    end
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = cpu_idx;
    wr_way   = hit_way;
    wr_tag   = cpu_tag;
    wr_data  = cpu_wdata;
    start_rd = 1'b0;
    start_wr = 1'b0;
    fill     = 1'b0;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The cycle after a write-through completes, the core still presents that
        // write; it must see stall=0 here rather than start a second write.
        if (wr_done_q) begin
          stall = 1'b0;
        end else if (cpu_we) begin
          stall    = 1'b1;
          wr_en    = hit;
          start_wr = 1'b1;
          state_d  = StWrThru;
        end else if (cpu_re) begin
          if (hit) begin
            hit_inc = 1'b1;
          end else begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            start_rd = 1'b1;
            state_d  = StRdMiss;
          end
        end
      end
      StRdMiss: begin
        stall = 1'b1;
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_idx  = miss_idx_q;
          wr_way  = victim_way;
          wr_tag  = miss_tag_q;
          wr_data = mem_rdata;
          fill    = 1'b1;
          state_d = StFill;
        end
      end
      StWrThru: begin
        stall = 1'b1;
        if (mem_ack) state_d = StIdle;
      end
      StFill: begin
        stall   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cpu_rdata = (state_q == StIdle && !wr_done_q && !cpu_we && cpu_re && hit) ? hit_data
                                                                                   : rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      miss_idx_q  <= '0;
      miss_tag_q  <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_done_q   <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      for (int s = 0; s < int'(SETS); s++) fifo_ptr_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      wr_done_q <= (state_q == StWrThru) && mem_ack;
      if (start_rd) begin
        miss_idx_q <= cpu_idx;
        miss_tag_q <= cpu_tag;
        mem_req_q  <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= cpu_addr;
      end else if (start_wr) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= cpu_addr;
        mem_wdata_q <= cpu_wdata;
      end else if (mem_ack && (state_q == StRdMiss || state_q == StWrThru)) begin
        mem_req_q <= 1'b0;
      end
      if (fill) begin
        rdata_q <= mem_rdata;
        if (use_fifo) begin
          fifo_ptr_q[miss_idx_q] <= (fifo_ptr_q[miss_idx_q] == WAY_W'(WAYS - 1)) ? '0
                                    : fifo_ptr_q[miss_idx_q] + WAY_W'(1);
        end
      end
      if (hit_inc && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cache_assoc_fifo.sv
module tb_cache_assoc_fifo;
  localparam int unsigned SETS = 16;
  localparam int unsigned WAYS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_re = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall, mem_req, mem_we;
  logic [15:0] hit_cnt, miss_cnt;
  // Second instance with 2-bit counters, driven by the same inputs.
  logic [31:0] s_rdata, s_mem_addr, s_mem_wdata;
  logic        s_stall, s_mem_req, s_mem_we;
  logic [1:0]  s_hit_cnt, s_miss_cnt;

  always #5 clk = ~clk;

  cache_assoc_fifo #(.DATA_W(32), .ADDR_W(32), .SETS(SETS), .WAYS(WAYS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  cache_assoc_fifo #(.DATA_W(32), .ADDR_W(32), .SETS(SETS), .WAYS(WAYS), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(s_rdata), .stall(s_stall), .mem_req(s_mem_req),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Memory contents as the program sees them, plus per-set FIFO of resident line addresses.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dram    [logic [31:0]];
  logic [31:0] line_addr [SETS][WAYS];
  int          fill_cnt  [SETS];
  int          m_hits = 0, m_misses = 0;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} mem_exp_t;
  typedef struct packed {logic [31:0] rdata; logic hit;} rd_exp_t;
  mem_exp_t mem_q[$];
  rd_exp_t  rd_q[$];

  function automatic bit model_hit(input logic [31:0] a);
    int s = int'(a[3:0]);
    for (int i = 0; i < fill_cnt[s]; i++) if (line_addr[s][i] == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_insert(input logic [31:0] a);
    int s = int'(a[3:0]);
    if (fill_cnt[s] < int'(WAYS)) begin
      line_addr[s][fill_cnt[s]] = a;
      fill_cnt[s]++;
    end else begin
      for (int i = 0; i < int'(WAYS) - 1; i++) line_addr[s][i] = line_addr[s][i+1];
      line_addr[s][WAYS-1] = a;
    end
  endfunction

  function automatic logic [31:0] get_ref(input logic [31:0] a);
    logic [31:0] v;
    if (!ref_mem.exists(a)) begin
      v = $urandom;
      ref_mem[a] = v;
      dram[a] = v;
    end
    return ref_mem[a];
  endfunction

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  // ---------------- DRAM responder ----------------
  bit mem_auto = 1'b1;
  int fixed_lat = 0;
  int last_lat = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_auto && rst_n && mem_req) begin
        mem_exp_t e;
        int lat;
        if (mem_q.size() == 0) begin
          check("mem_unexpected_req", 64'(mem_req), 64'(0));
        end else begin
          e = mem_q.pop_front();
          check("mem_we", 64'(mem_we), 64'(e.we));
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) check("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        last_lat = lat;
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          check("mem_req_held", 64'(mem_req), 64'(1));
        end
        mem_ack = 1'b1;
        if (mem_we) dram[mem_addr] = mem_wdata;
        else mem_rdata = dram.exists(mem_addr) ? dram[mem_addr] : 32'hBAD0_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------- read-response monitor ----------------
  int stall_run = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_run = 0;
    end else if (cpu_re && !cpu_we) begin
      if (stall) begin
        stall_run++;
      end else begin
        rd_exp_t e;
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 64'(cpu_rdata), 64'(0));
        end else begin
          e = rd_q.pop_front();
          check("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
          check("read_stall_cycles", 64'(stall_run), e.hit ? 64'(0) : 64'(last_lat + 1));
        end
        stall_run = 0;
      end
    end else begin
      stall_run = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_model();
    m_hits = 0;
    m_misses = 0;
    for (int s = 0; s < int'(SETS); s++) fill_cnt[s] = 0;
    rd_q.delete();
    mem_q.delete();
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic do_op(input bit we, input bit re_too, input logic [31:0] a,
                       input logic [31:0] wd);
    int n;
    if (we) begin
      ref_mem[a] = wd;
      mem_q.push_back({1'b1, a, wd});
    end else begin
      rd_exp_t e;
      e.rdata = get_ref(a);
      e.hit = model_hit(a);
      rd_q.push_back(e);
      if (e.hit) m_hits++;
      else begin
        m_misses++;
        mem_q.push_back({1'b0, a, 32'h0});
        model_insert(a);
      end
    end
    @(posedge clk);
    #1;
    cpu_we = we;
    cpu_re = we ? re_too : 1'b1;
    cpu_addr = a;
    cpu_wdata = wd;
    n = 0;
    @(negedge clk);
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("stall_timeout", 64'(n), 64'(0));
    else if (we) check("write_stall_cycles", 64'(n), 64'(last_lat + 1));
    @(posedge clk);
    #1;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    @(negedge clk);
    check("idle_stall", 64'(stall), 64'(0));
    check("hit_cnt", 64'(hit_cnt), 64'(m_hits));
    check("miss_cnt", 64'(miss_cnt), 64'(m_misses));
    check("hit_cnt_sat", 64'(s_hit_cnt), 64'(sat2(m_hits)));
    check("miss_cnt_sat", 64'(s_miss_cnt), 64'(sat2(m_misses)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, 64'(stall), 64'(0));
    check({tag, "_mem_req"}, 64'(mem_req), 64'(0));
    check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    check({tag, "_cpu_rdata"}, 64'(cpu_rdata), 64'(0));
    check({tag, "_hit_cnt"}, 64'(hit_cnt), 64'(0));
    check({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(0));
  endtask

  initial begin
    clear_model();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold miss with 3-cycle DRAM, then hit, write-hit, write-miss.
    fixed_lat = 3;
    ref_mem[32'h10] = 32'hDEADBEEF;
    dram[32'h10] = 32'hDEADBEEF;
    do_op(1'b0, 1'b0, 32'h10, 32'h0);
    do_op(1'b0, 1'b0, 32'h10, 32'h0);
    do_op(1'b1, 1'b0, 32'h10, 32'h12345678);
    do_op(1'b0, 1'b0, 32'h10, 32'h0);
    do_op(1'b1, 1'b1, 32'h20, 32'hA5A5_0020);
    do_op(1'b0, 1'b0, 32'h20, 32'h0);

    // FIFO eviction in set 0.
    reset_dut();
    fixed_lat = 0;
    for (int i = 0; i < 5; i++) do_op(1'b0, 1'b0, 32'(i * 16), 32'h0);
    do_op(1'b0, 1'b0, 32'h10, 32'h0);
    do_op(1'b0, 1'b0, 32'h00, 32'h0);
    do_op(1'b0, 1'b0, 32'h10, 32'h0);

    // Reset during an outstanding read miss; the late ack must be ignored.
    reset_dut();
    mem_auto = 1'b0;
    ref_mem[32'h50] = 32'h0BADCAFE;
    dram[32'h50] = 32'h0BADCAFE;
    @(posedge clk);
    #1;
    cpu_re = 1'b1;
    cpu_addr = 32'h50;
    @(negedge clk);
    check("rst_miss_stall", 64'(stall), 64'(1));
    @(negedge clk);
    check("rst_miss_req", 64'(mem_req), 64'(1));
    check("rst_miss_addr", 64'(mem_addr), 64'(32'h50));
    @(negedge clk);
    rst_n = 1'b0;
    cpu_re = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_req", 64'(mem_req), 64'(0));
    check("late_ack_stall", 64'(stall), 64'(0));
    mem_auto = 1'b1;
    do_op(1'b0, 1'b0, 32'h50, 32'h0);

    // Saturation of the 2-bit counters: one miss then five hits.
    reset_dut();
    do_op(1'b0, 1'b0, 32'h7, 32'h0);
    for (int i = 0; i < 5; i++) do_op(1'b0, 1'b0, 32'h7, 32'h0);
    check("sat_hit_cnt_final", 64'(s_hit_cnt), 64'(2'd3));

    // Randomized traffic over a small address pool so sets collide and evict.
    for (int i = 0; i < 300; i++) begin
      bit we;
      we = ($urandom_range(0, 2) == 0);
      do_op(we, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)), $urandom);
    end

    repeat (5) @(negedge clk);
    check("rd_queue_drained", 64'(rd_q.size()), 64'(0));
    check("mem_queue_drained", 64'(mem_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
